fb_conditioner: RTL and testbench
=================================

FB_CONDITIONER -- requirements
Module: fb_conditioner

Interface
REQ-001 Parameter FILT_LEN, default 4: consecutive disagreeing samples required before the filtered level changes; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 2000: cycles without a filtered edge before nosig asserts; legal range 1..2^20-1.
REQ-003 Parameter PER_W, default 16: width of period and of the internal period counter.
REQ-004 clk_50  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 fb_u  input  1  raw asynchronous feedback pin.
REQ-007 fb  output  1  synchronized, glitch-filtered feedback level.
REQ-008 fb_rise  output  1  one-cycle pulse on each 0->1 of fb.
REQ-009 period  output  PER_W  last measured rise-to-rise interval, in clk_50 cycles.
REQ-010 period_vld  output  1  one-cycle pulse when period updates.
REQ-011 nosig  output  1  high while no fb edge has occurred for TIMEOUT cycles.
REQ-012 glitch_cnt  output  8  saturating count of rejected pulses.

Function
REQ-013 fb_u SHALL pass through a 2-flop synchronizer; the second-stage output is fb_s.
REQ-014 A filter counter SHALL increment each cycle fb_s != fb and clear each cycle fb_s == fb.
REQ-015 When the filter counter would reach FILT_LEN, fb SHALL toggle in that cycle and the counter SHALL clear.
REQ-016 Latency: a clean level change on fb_u SHALL appear on fb at the (FILT_LEN+2)th rising edge after the first edge that samples the new level.
REQ-017 A disagreement run of 1..FILT_LEN-1 cycles that ends with fb_s == fb SHALL increment glitch_cnt by 1; glitch_cnt SHALL saturate at 255.
REQ-018 fb_rise SHALL be high for exactly the first cycle in which fb is 1 after being 0; there SHALL be no pulse on 1->0.
REQ-019 Period counter per_ctr SHALL increment each cycle, saturating at 2^PER_W-1.
REQ-020 In the fb_rise cycle, per_ctr SHALL load 1, so rises N cycles apart present per_ctr == N at the second rise.
REQ-021 In the fb_rise cycle, if armed and per_ctr is not saturated, the next edge SHALL load period <= per_ctr and pulse period_vld.
REQ-022 A rise when not armed, or when per_ctr is saturated, SHALL produce no period_vld and SHALL leave period unchanged.
REQ-023 Every rise SHALL set armed.
REQ-024 Idle counter SHALL clear on any fb toggle, else increment saturating at TIMEOUT.
REQ-025 nosig SHALL equal (idle counter == TIMEOUT).
REQ-026 When nosig is set, armed SHALL clear, so the first rise after signal loss only re-arms.
REQ-027 nosig SHALL deassert in the cycle after the fb toggle; that toggle resets the idle counter.

Reset
REQ-028 On rst, all outputs SHALL go to 0 immediately and asynchronously: fb, fb_rise, period, period_vld, nosig, glitch_cnt.
REQ-029 On rst, synchronizer flops, filter counter, per_ctr, idle counter and armed SHALL all clear.
REQ-030 After rst deasserts with fb_u idle, nosig SHALL assert TIMEOUT cycles later.
REQ-031 rst asserted mid-measurement SHALL discard the partial period; the first rise after reset SHALL not report.

Verification
REQ-032 Defaults, rst released, fb_u=0 for 2100 cycles -> fb=0, no fb_rise, nosig rises at cycle 2000, glitch_cnt=0.
REQ-033 fb_u square wave, period 400 cycles, 50% duty -> fb lags by FILT_LEN+2=6 edges. First rise gives no period_vld; every later rise gives period_vld with period=400; nosig stays 0.
REQ-034 fb_u low, then a 3-cycle high pulse -> fb stays 0 and glitch_cnt=1. Then a 6-cycle high pulse -> fb high for 6 cycles, fb_rise once, glitch_cnt stays 1. Then 300 3-cycle pulses -> glitch_cnt=255.
REQ-035 400-cycle square wave, then fb_u held low 2500 cycles, then square wave resumes -> nosig asserts 2000 cycles after the last fb toggle and deasserts the cycle after the next toggle. First rise after resume has no period_vld; the second reports 400.
REQ-036 TIMEOUT=100000, rises 70000 cycles apart -> no period_vld, period keeps its prior value. Next rises 400 apart -> period_vld with period=400.
REQ-037 rst pulsed for 1 cycle mid-way through a 400-cycle wave -> all outputs 0 during rst. The first rise after release gives no period_vld; the second reports 400.

Source files
------------

// File: rtl/fb_conditioner.sv
// Feedback pin conditioner for the clk_50 domain.
// - Synchronizes the raw asynchronous pin and debounces it with a run-length filter.
// - Counts rejected short pulses.
// - Measures the rise-to-rise period.
// - Flags loss of signal after TIMEOUT cycles without a filtered edge.
module fb_conditioner #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned TIMEOUT  = 2000,
    parameter int unsigned PER_W    = 16
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             fb_u,
    output logic             fb,
    output logic             fb_rise,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             nosig,
    output logic [7:0]       glitch_cnt
);

    localparam int unsigned IdleW = 20;

    localparam logic [3:0]       FiltLenV = 4'(FILT_LEN);
    localparam logic [IdleW-1:0] TmoV     = IdleW'(TIMEOUT);
    localparam logic [PER_W-1:0] PerMax   = '1;

    // Synchronizer
    logic sync1_q, sync2_q;

    // Glitch filter
    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic       fb_q, fb_d;
    logic       toggle;
    logic [7:0] glitch_q, glitch_d;

    // Edge detect and period measurement
    logic             fb_rise_q, fb_rise_d;
    logic [PER_W-1:0] per_ctr_q, per_ctr_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             period_vld_q, period_vld_d;
    logic             armed_q, armed_d;

    // Loss-of-signal detection
    logic [IdleW-1:0] idle_q, idle_d;
    logic             nosig_q, nosig_d;

    // Two-flop synchronizer for the raw pin; sync2_q is the usable sample.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= fb_u;
            sync2_q <= sync1_q;
        end
    end

    // Run-length filter: the level flips once the sample disagrees for FILT_LEN cycles.
    // A shorter run that collapses back counts as a glitch.
    always_comb begin
        filt_cnt_d = '0;
        fb_d       = fb_q;
        glitch_d   = glitch_q;
        toggle     = 1'b0;
        if (sync2_q != fb_q) begin
            if (filt_cnt_q + 4'd1 == FiltLenV) begin
                fb_d   = ~fb_q;
                toggle = 1'b1;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end else if (filt_cnt_q != 4'd0 && glitch_q != 8'hff) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    // Rise pulse coincides with the first high cycle of fb.
    always_comb begin
        fb_rise_d = toggle & ~fb_q;
    end

    // Period counter restarts at 1 in the rise cycle.
    // A measurement is published only when a previous rise armed it and the counter has not saturated.
    always_comb begin
        period_d     = period_q;
        period_vld_d = 1'b0;
        if (fb_rise_q) begin
            per_ctr_d = {{(PER_W-1){1'b0}}, 1'b1};
        end else if (per_ctr_q != PerMax) begin
            per_ctr_d = per_ctr_q + {{(PER_W-1){1'b0}}, 1'b1};
        end else begin
            per_ctr_d = per_ctr_q;
        end
        if (fb_rise_q && armed_q && per_ctr_q != PerMax) begin
            period_d     = per_ctr_q;
            period_vld_d = 1'b1;
        end
    end

    // Every rise arms the next measurement; signal loss disarms so the next rise only re-arms.
    always_comb begin
        if (fb_rise_q) begin
            armed_d = 1'b1;
        end else if (nosig_q) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // Idle counter restarts on any filtered toggle and saturates at TIMEOUT.
    always_comb begin
        if (toggle) begin
            idle_d = '0;
        end else if (idle_q != TmoV) begin
            idle_d = idle_q + {{(IdleW-1){1'b0}}, 1'b1};
        end else begin
            idle_d = idle_q;
        end
        nosig_d = (idle_d == TmoV);
    end

    // State registers for filter, measurement and idle tracking.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            filt_cnt_q   <= '0;
            fb_q         <= 1'b0;
            glitch_q     <= '0;
            fb_rise_q    <= 1'b0;
            per_ctr_q    <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            armed_q      <= 1'b0;
            idle_q       <= '0;
            nosig_q      <= 1'b0;
        end else begin
            filt_cnt_q   <= filt_cnt_d;
            fb_q         <= fb_d;
            glitch_q     <= glitch_d;
            fb_rise_q    <= fb_rise_d;
            per_ctr_q    <= per_ctr_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            armed_q      <= armed_d;
            idle_q       <= idle_d;
            nosig_q      <= nosig_d;
        end
    end

    // All outputs come straight from flops.
    always_comb begin
        fb         = fb_q;
        fb_rise    = fb_rise_q;
        period     = period_q;
        period_vld = period_vld_q;
        nosig      = nosig_q;
        glitch_cnt = glitch_q;
    end

endmodule

// File: tb/tb_fb_conditioner.sv
// Randomized/directed bench for fb_conditioner.
// Two instances share the pin and reset:
//   - instance A uses the default parameters;
//   - instance B has a narrow period counter and a short timeout, so it exercises saturation.
// Both are compared every cycle against a timestamp-based model.
module tb_fb_conditioner;

    localparam int unsigned PerWB = 8;
    localparam int unsigned TmoB  = 1000;

    logic             clk_50 = 1'b0;
    logic             rst;
    logic             fb_u;
    logic             fb_a, fb_rise_a, period_vld_a, nosig_a;
    logic [15:0]      period_a;
    logic [7:0]       glitch_a;
    logic             fb_b, fb_rise_b, period_vld_b, nosig_b;
    logic [PerWB-1:0] period_b;
    logic [7:0]       glitch_b;

    int n_checks = 0;
    int n_errors = 0;

    fb_conditioner dut_a (
        .clk_50     (clk_50),
        .rst        (rst),
        .fb_u       (fb_u),
        .fb         (fb_a),
        .fb_rise    (fb_rise_a),
        .period     (period_a),
        .period_vld (period_vld_a),
        .nosig      (nosig_a),
        .glitch_cnt (glitch_a)
    );

    fb_conditioner #(
        .FILT_LEN (4),
        .TIMEOUT  (TmoB),
        .PER_W    (PerWB)
    ) dut_b (
        .clk_50     (clk_50),
        .rst        (rst),
        .fb_u       (fb_u),
        .fb         (fb_b),
        .fb_rise    (fb_rise_b),
        .period     (period_b),
        .period_vld (period_vld_b),
        .nosig      (nosig_b),
        .glitch_cnt (glitch_b)
    );

    always #5 clk_50 = ~clk_50;

    // Reference model state: time is an edge count since reset.
    // Period and idle time are differences of timestamps.
    typedef struct {
        bit h1, h2, fb, rise, vld, armed, nosig, pend_vld;
        int run, glitch, period, pend_per, n, last_toggle, last_rise;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t m_init();
        mstate_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic m_step(inout mstate_t st, input bit fbu, input int filt, input int tmo,
                          input int pmax);
        bit fbs, nosig_pre, toggled;
        int diff;
        fbs       = st.h2;
        st.h2     = st.h1;
        st.h1     = fbu;
        nosig_pre = st.nosig;
        st.n++;
        st.vld = st.pend_vld;
        if (st.pend_vld) st.period = st.pend_per;
        st.pend_vld = 0;
        toggled = 0;
        if (fbs != st.fb) begin
            st.run++;
            if (st.run >= filt) begin
                st.fb   = !st.fb;
                st.run  = 0;
                toggled = 1;
            end
        end else begin
            if (st.run > 0 && st.glitch < 255) st.glitch++;
            st.run = 0;
        end
        if (nosig_pre) st.armed = 0;
        st.rise = toggled && st.fb;
        if (st.rise) begin
            diff = st.n - st.last_rise;
            if (st.armed && diff < pmax) begin
                st.pend_vld = 1;
                st.pend_per = diff;
            end
            st.armed     = 1;
            st.last_rise = st.n;
        end
        if (toggled) st.last_toggle = st.n;
        st.nosig = (st.n - st.last_toggle) >= tmo;
    endtask

    // Advance both models on each rising edge; reset holds them at their initial state.
    always @(posedge clk_50) begin
        if (rst) begin
            ma = m_init();
            mb = m_init();
        end else begin
            m_step(ma, fb_u, 4, 2000, 65535);
            m_step(mb, fb_u, 4, int'(TmoB), (1 << PerWB) - 1);
        end
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_fb",      32'(fb_a),         32'(ma.fb));
        chk("a_fb_rise", 32'(fb_rise_a),    32'(ma.rise));
        chk("a_period",  32'(period_a),     32'(ma.period));
        chk("a_vld",     32'(period_vld_a), 32'(ma.vld));
        chk("a_nosig",   32'(nosig_a),      32'(ma.nosig));
        chk("a_glitch",  32'(glitch_a),     32'(ma.glitch));
        chk("b_fb",      32'(fb_b),         32'(mb.fb));
        chk("b_fb_rise", 32'(fb_rise_b),    32'(mb.rise));
        chk("b_period",  32'(period_b),     32'(mb.period));
        chk("b_vld",     32'(period_vld_b), 32'(mb.vld));
        chk("b_nosig",   32'(nosig_b),      32'(mb.nosig));
        chk("b_glitch",  32'(glitch_b),     32'(mb.glitch));
    endtask

    task automatic hold(input bit v, input int n);
        repeat (n) begin
            @(negedge clk_50);
            check_all();
            fb_u = v;
        end
    endtask

    task automatic wave(input int half, input int count);
        repeat (count) begin
            hold(1'b1, half);
            hold(1'b0, half);
        end
    endtask

    // Assert reset between edges and confirm outputs drop before any clock edge arrives.
    task automatic do_reset(input int n);
        @(negedge clk_50);
        check_all();
        rst = 1'b1;
        ma  = m_init();
        mb  = m_init();
        #1;
        chk("rst_async_fb",    32'(fb_a | fb_b),                 0);
        chk("rst_async_rise",  32'(fb_rise_a | fb_rise_b),       0);
        chk("rst_async_per",   32'(period_a) | 32'(period_b),    0);
        chk("rst_async_vld",   32'(period_vld_a | period_vld_b), 0);
        chk("rst_async_nosig", 32'(nosig_a | nosig_b),           0);
        chk("rst_async_glt",   32'(glitch_a | glitch_b),         0);
        repeat (n) begin
            @(negedge clk_50);
            check_all();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        fb_u = 1'b0;
        ma   = m_init();
        mb   = m_init();
        repeat (3) @(negedge clk_50);
        rst = 1'b0;

        // Idle pin after reset: nosig appears after TIMEOUT cycles.
        hold(1'b0, 2100);
        chk("a_nosig_after_idle", 32'(nosig_a), 1);

        // Clean 400-cycle square wave.
        wave(200, 5);

        // Short glitch, a just-accepted pulse, then glitch saturation.
        hold(1'b0, 20);
        hold(1'b1, 3);
        hold(1'b0, 20);
        chk("a_glitch_one", 32'(glitch_a), 1);
        hold(1'b1, 6);
        hold(1'b0, 30);
        chk("a_glitch_still_one", 32'(glitch_a), 1);
        repeat (300) begin
            hold(1'b1, 3);
            hold(1'b0, 10);
        end
        chk("a_glitch_sat", 32'(glitch_a), 255);

        // Signal loss and resume.
        wave(200, 3);
        hold(1'b0, 2500);
        wave(200, 3);

        // Rises 300 apart saturate the 8-bit counter of instance B; then 200 apart report.
        wave(150, 3);
        wave(100, 3);

        // Random levels, mixing glitches with long holds.
        repeat (80) begin
            if ($urandom_range(0, 2) == 0) hold(1'($urandom_range(0, 1)), $urandom_range(1, 5));
            else hold(1'($urandom_range(0, 1)), $urandom_range(1, 80));
        end

        // Reset mid-measurement, then the wave continues.
        hold(1'b0, 50);
        wave(200, 2);
        hold(1'b1, 150);
        do_reset(1);
        hold(1'b1, 50);
        hold(1'b0, 200);
        wave(200, 3);
        hold(1'b0, 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
